btn_digit_editor: RTL and testbench

- Parametrised successor to the front-panel left/right digit selector.
- Synchronises and edge-detects the five panel buttons and moves a cursor over a DIGITS-wide register of DIGIT_W-bit digits, with wrap.
- Adds in-place digit editing (up/down modulo RADIX), preload from the ATM core, and a valid/ready commit of the edited word.
- Sits between the debounced button pins and the ATM control FSM and display mux, and is used for PIN and amount entry.

---
 rtl/btn_digit_editor.sv | 210 +++++++++++++++++++++
 tb/tb_btn_digit_editor.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_digit_editor.sv
// Front-panel digit editor: synchronises and edge-detects five panel buttons, moves a cursor over
// a DIGITS-wide word, edits the selected digit modulo RADIX, accepts preloads from the ATM core
// and hands the finished word to a consumer over a valid/ready handshake.
module btn_digit_editor #(
  parameter int unsigned DIGITS  = 8,
  parameter int unsigned DIGIT_W = 4,
  parameter int unsigned RADIX   = 10,
  localparam int unsigned SEL_W  = $clog2(DIGITS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [4:0]                  btn,
  input  logic                        load_valid,
  input  logic [DIGITS*DIGIT_W-1:0]   load_data,
  input  logic                        out_ready,
  output logic [SEL_W-1:0]            sel_o,
  output logic [DIGIT_W-1:0]          digit_o,
  output logic [DIGITS*DIGIT_W-1:0]   value_o,
  output logic                        out_valid,
  output logic                        busy_o
);

  localparam int unsigned WordW = DIGITS * DIGIT_W;

  // Highest cursor position and highest legal digit value.
  localparam logic [SEL_W-1:0]   SelMax   = SEL_W'(DIGITS - 1);
  localparam logic [DIGIT_W-1:0] DigitMax = DIGIT_W'(RADIX - 1);

  // Button bit positions.
  localparam int unsigned BtnLeft   = 0;
  localparam int unsigned BtnRight  = 1;
  localparam int unsigned BtnUp     = 2;
  localparam int unsigned BtnDown   = 3;
  localparam int unsigned BtnCommit = 4;

  typedef enum logic [0:0] {
    StEdit,
    StCommit
  } state_e;

  // At most one button action is taken per cycle.
  typedef enum logic [2:0] {
    ActNone,
    ActLeft,
    ActRight,
    ActUp,
    ActDown,
    ActCommit
  } act_e;

  logic [4:0]         btn_meta_q, btn_meta_d;
  logic [4:0]         btn_sync_q, btn_sync_d;
  logic [4:0]         btn_prev_q, btn_prev_d;
  logic [4:0]         btn_edge;
  act_e               act;
  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [WordW-1:0]   value_q, value_d;
  logic [DIGIT_W-1:0] cur_digit;
  logic [DIGIT_W-1:0] digit_up;
  logic [DIGIT_W-1:0] digit_dn;
  logic [DIGIT_W-1:0] new_digit;
  logic               digit_wr;

  // Up: wraps to zero from RADIX-1, and also from any out-of-range loaded value.
  function automatic logic [DIGIT_W-1:0] digit_inc(input logic [DIGIT_W-1:0] d);
    if (d >= DigitMax) begin
      return '0;
    end
    return d + DIGIT_W'(1);
  endfunction

  // Down: wraps to RADIX-1 from zero; out-of-range loaded values clamp to RADIX-1.
  function automatic logic [DIGIT_W-1:0] digit_dec(input logic [DIGIT_W-1:0] d);
    if (d == '0) begin
      return DigitMax;
    end else if (d > DigitMax) begin
      return DigitMax;
    end
    return d - DIGIT_W'(1);
  endfunction

  // Two-stage synchroniser followed by a previous-value stage for rising-edge detection.
  always_comb begin
    btn_meta_d = btn;
    btn_sync_d = btn_meta_q;
    btn_prev_d = btn_sync_q;
    btn_edge   = btn_sync_q & ~btn_prev_q;
  end

  // Fixed-priority pick of a single action: left > right > up > down > commit.
  always_comb begin
    act = ActNone;
    if (btn_edge[BtnLeft]) begin
      act = ActLeft;
    end else if (btn_edge[BtnRight]) begin
      act = ActRight;
    end else if (btn_edge[BtnUp]) begin
      act = ActUp;
    end else if (btn_edge[BtnDown]) begin
      act = ActDown;
    end else if (btn_edge[BtnCommit]) begin
      act = ActCommit;
    end
  end

  // Mux out the digit under the cursor; sel never exceeds DIGITS-1.
  always_comb begin
    cur_digit = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (sel_q == SEL_W'(i)) begin
        cur_digit = value_q[i*DIGIT_W +: DIGIT_W];
      end
    end
  end

  // Candidate values for the selected digit.
  always_comb begin
    digit_up = digit_inc(cur_digit);
    digit_dn = digit_dec(cur_digit);
  end

  // Editor FSM next state; loads beat button actions and COMMIT discards both.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    new_digit = cur_digit;
    digit_wr  = 1'b0;
    unique case (state_q)
      StEdit: begin
        if (load_valid) begin
          sel_d = '0;
        end else begin
          unique case (act)
            ActLeft: begin
              sel_d = (sel_q == SelMax) ? '0 : sel_q + SEL_W'(1);
            end
            ActRight: begin
              sel_d = (sel_q == '0) ? SelMax : sel_q - SEL_W'(1);
            end
            ActUp: begin
              new_digit = digit_up;
              digit_wr  = 1'b1;
            end
            ActDown: begin
              new_digit = digit_dn;
              digit_wr  = 1'b1;
            end
            ActCommit: begin
              state_d = StCommit;
            end
            default: begin
            end
          endcase
        end
      end
      StCommit: begin
        if (out_ready) begin
          state_d = StEdit;
        end
      end
      default: begin
        state_d = StEdit;
      end
    endcase
  end

  // Working word next state: whole-word preload or a single-digit write at the cursor.
  always_comb begin
    value_d = value_q;
    if (state_q == StEdit && load_valid) begin
      value_d = load_data;
    end else if (digit_wr) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (sel_q == SEL_W'(i)) begin
          value_d[i*DIGIT_W +: DIGIT_W] = new_digit;
        end
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_meta_q <= '0;
      btn_sync_q <= '0;
      btn_prev_q <= '0;
      state_q    <= StEdit;
      sel_q      <= '0;
      value_q    <= '0;
    end else begin
      btn_meta_q <= btn_meta_d;
      btn_sync_q <= btn_sync_d;
      btn_prev_q <= btn_prev_d;
      state_q    <= state_d;
      sel_q      <= sel_d;
      value_q    <= value_d;
    end
  end

  // The committed word stays offered for exactly as long as the FSM sits in COMMIT.
  always_comb begin
    sel_o     = sel_q;
    value_o   = value_q;
    digit_o   = cur_digit;
    out_valid = (state_q == StCommit);
    busy_o    = (state_q == StCommit);
  end

endmodule

// File: tb/tb_btn_digit_editor.sv
// Bench for btn_digit_editor: directed vector table, hand-written corner sequences and a
// randomized run checked against a digit-array reference model.
module tb_btn_digit_editor;

  localparam int unsigned D = 8;
  localparam int unsigned W = 4;
  localparam int unsigned R = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  btn;
  logic        load_valid;
  logic [31:0] load_data;
  logic        out_ready;
  logic [2:0]  sel;
  logic [3:0]  digit;
  logic [31:0] value;
  logic        out_valid;
  logic        busy;

  // Six-digit instance for non-power-of-two wrap.
  logic [4:0]  btn6;
  logic        lv6 = 1'b0;
  logic [23:0] ld6 = '0;
  logic        rdy6 = 1'b0;
  logic [2:0]  sel6;
  logic [3:0]  digit6;
  logic [23:0] value6;
  logic        ov6;
  logic        busy6;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  btn_digit_editor #(.DIGITS(D), .DIGIT_W(W), .RADIX(R)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn        (btn),
    .load_valid (load_valid),
    .load_data  (load_data),
    .out_ready  (out_ready),
    .sel_o      (sel),
    .digit_o    (digit),
    .value_o    (value),
    .out_valid  (out_valid),
    .busy_o     (busy)
  );

  btn_digit_editor #(.DIGITS(6), .DIGIT_W(4), .RADIX(10)) u_dut6 (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn        (btn6),
    .load_valid (lv6),
    .load_data  (ld6),
    .out_ready  (rdy6),
    .sel_o      (sel6),
    .digit_o    (digit6),
    .value_o    (value6),
    .out_valid  (ov6),
    .busy_o     (busy6)
  );

  // Reference model: digits as integers, cursor as integer, and the last three sampled button
  // vectors (a press sampled at edge k acts at edge k+2, once, on its rising transition).
  int         md[D];
  int         msel;
  bit         mcommit;
  logic [4:0] h1, h2, h3;
  bit         model_live = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_word();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < D; i++) v[i*W +: W] = md[i][3:0];
    return v;
  endfunction

  task automatic model_step();
    logic [4:0] e;
    if (!rst_n) begin
      for (int i = 0; i < D; i++) md[i] = 0;
      msel = 0;
      mcommit = 1'b0;
      h1 = '0; h2 = '0; h3 = '0;
      model_live = 1'b1;
      return;
    end
    e = h2 & ~h3;
    if (mcommit) begin
      if (out_ready) mcommit = 1'b0;
    end else if (load_valid) begin
      for (int i = 0; i < D; i++) md[i] = int'(load_data[i*W +: W]);
      msel = 0;
    end else if (e[0]) begin
      msel = (msel + 1) % D;
    end else if (e[1]) begin
      msel = (msel + D - 1) % D;
    end else if (e[2]) begin
      md[msel] = (md[msel] >= R - 1) ? 0 : md[msel] + 1;
    end else if (e[3]) begin
      if (md[msel] == 0 || md[msel] > R - 1) md[msel] = R - 1;
      else md[msel] = md[msel] - 1;
    end else if (e[4]) begin
      mcommit = 1'b1;
    end
    h3 = h2; h2 = h1; h1 = btn;
  endtask

  task automatic model_check();
    if (model_live) begin
      chk("m_sel", 32'(sel), 32'(msel));
      chk("m_value", value, model_word());
      chk("m_digit", 32'(digit), 32'(md[msel]));
      chk("m_valid", 32'(out_valid), 32'(mcommit));
      chk("m_busy", 32'(busy), 32'(mcommit));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    model_check();
  endtask

  typedef struct {
    logic        rst_n;
    logic [4:0]  btn;
    logic        lv;
    logic [31:0] ld;
    logic        rdy;
    logic [2:0]  esel;
    logic [31:0] eval;
    logic        eov;
  } vec_t;

  function automatic vec_t mk(logic r, logic [4:0] b, logic lv, logic [31:0] ld, logic [2:0] es,
                              logic [31:0] ev, logic eov);
    vec_t v;
    v.rst_n = r; v.btn = b; v.lv = lv; v.ld = ld; v.rdy = 1'b0;
    v.esel = es; v.eval = ev; v.eov = eov;
    return v;
  endfunction

  localparam logic [4:0] BL = 5'b00001, BR = 5'b00010, BU = 5'b00100, BD = 5'b01000;
  localparam logic [4:0] BC = 5'b10000, B0 = 5'b00000;

  vec_t tbl[38];

  initial begin
    // Each row: inputs held for one edge, expected outputs after that edge.
    tbl[0]  = mk(0, B0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, B0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1, BL, 0, 0, 0, 0, 0);
    tbl[3]  = mk(1, BL, 0, 0, 0, 0, 0);
    tbl[4]  = mk(1, B0, 0, 0, 1, 0, 0);
    tbl[5]  = mk(1, B0, 0, 0, 1, 0, 0);
    tbl[6]  = mk(1, BR, 0, 0, 1, 0, 0);
    tbl[7]  = mk(1, B0, 0, 0, 1, 0, 0);
    tbl[8]  = mk(1, B0, 0, 0, 0, 0, 0);
    tbl[9]  = mk(1, BR, 0, 0, 0, 0, 0);
    tbl[10] = mk(1, B0, 0, 0, 0, 0, 0);
    tbl[11] = mk(1, B0, 0, 0, 7, 0, 0);
    tbl[12] = mk(1, B0, 1, 32'h0000_0009, 0, 32'h9, 0);
    tbl[13] = mk(1, BU, 0, 0, 0, 32'h9, 0);
    tbl[14] = mk(1, B0, 0, 0, 0, 32'h9, 0);
    tbl[15] = mk(1, B0, 0, 0, 0, 32'h0, 0);
    tbl[16] = mk(1, BD, 0, 0, 0, 32'h0, 0);
    tbl[17] = mk(1, B0, 0, 0, 0, 32'h0, 0);
    tbl[18] = mk(1, B0, 0, 0, 0, 32'h9, 0);
    tbl[19] = mk(1, BD, 0, 0, 0, 32'h9, 0);
    tbl[20] = mk(1, B0, 0, 0, 0, 32'h9, 0);
    tbl[21] = mk(1, B0, 0, 0, 0, 32'h8, 0);
    tbl[22] = mk(1, BL | BU, 0, 0, 0, 32'h8, 0);
    tbl[23] = mk(1, B0, 0, 0, 0, 32'h8, 0);
    tbl[24] = mk(1, B0, 0, 0, 1, 32'h8, 0);
    tbl[25] = mk(1, BL, 0, 0, 1, 32'h8, 0);
    tbl[26] = mk(1, B0, 0, 0, 1, 32'h8, 0);
    tbl[27] = mk(1, B0, 1, 32'h0000_000F, 0, 32'hF, 0);
    tbl[28] = mk(1, BU, 0, 0, 0, 32'hF, 0);
    tbl[29] = mk(1, B0, 0, 0, 0, 32'hF, 0);
    tbl[30] = mk(1, B0, 0, 0, 0, 32'h0, 0);
    tbl[31] = mk(1, B0, 1, 32'h0000_000F, 0, 32'hF, 0);
    tbl[32] = mk(1, BD, 0, 0, 0, 32'hF, 0);
    tbl[33] = mk(1, B0, 0, 0, 0, 32'hF, 0);
    tbl[34] = mk(1, B0, 0, 0, 0, 32'h9, 0);
    tbl[35] = mk(1, BC, 0, 0, 0, 32'h9, 0);
    tbl[36] = mk(1, B0, 0, 0, 0, 32'h9, 0);
    tbl[37] = mk(1, B0, 0, 0, 0, 32'h9, 1);

    rst_n = 1'b0; btn = '0; load_valid = 1'b0; load_data = '0; out_ready = 1'b0; btn6 = '0;

    for (int i = 0; i < 38; i++) begin
      rst_n = tbl[i].rst_n; btn = tbl[i].btn; load_valid = tbl[i].lv;
      load_data = tbl[i].ld; out_ready = tbl[i].rdy;
      tick();
      chk($sformatf("tbl%0d_sel", i), 32'(sel), 32'(tbl[i].esel));
      chk($sformatf("tbl%0d_value", i), value, tbl[i].eval);
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].eov));
    end

    // COMMIT with no consumer: edits and loads must be ignored, word held.
    for (int c = 0; c < 5; c++) begin
      btn = (c % 2 == 0) ? (BU | BL) : B0;
      load_valid = (c == 2);
      load_data = 32'h1234_5678;
      tick();
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_busy", 32'(busy), 32'd1);
      chk("hold_value", value, 32'h9);
      chk("hold_sel", 32'(sel), 32'd0);
    end
    btn = B0; load_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("drain_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    tick();
    chk("xfer_valid", 32'(out_valid), 32'd0);
    chk("xfer_busy", 32'(busy), 32'd0);
    chk("xfer_value", value, 32'h9);
    out_ready = 1'b0;
    btn = BU; tick(); btn = B0; tick(); tick();
    chk("reedit_value", value, 32'h0);

    // Reset in the middle of a commit.
    btn = BC; tick(); btn = B0; tick(); tick();
    chk("commit2_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_value", value, 32'h0);
    chk("rst_sel", 32'(sel), 32'd0);
    btn = BL; tick(); btn = B0; tick(); tick();
    chk("post_rst_sel", 32'(sel), 32'd1);

    // Six-digit wrap in both directions.
    btn6 = BR; tick(); btn6 = B0; tick(); tick();
    chk("d6_right_wrap", 32'(sel6), 32'd5);
    chk("d6_digit", 32'(digit6), 32'd0);
    btn6 = BL; tick(); btn6 = B0; tick(); tick();
    chk("d6_left_wrap", 32'(sel6), 32'd0);
    chk("d6_value", 32'(value6), 32'd0);
    chk("d6_idle", 32'({ov6, busy6}), 32'd0);

    // Randomized run; buttons tend to be held for several cycles.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 2) == 0) btn = 5'($urandom_range(0, 31));
      rst_n = ($urandom_range(0, 99) != 0);
      load_valid = ($urandom_range(0, 15) == 0);
      load_data = $urandom;
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
